// File: rtl/mem_stage.sv
// ----------------------------------------------------------------------------
// mem_stage -- byte-serial memory access stage.
//
// Splits LB/LH/LW/LBU/LHU/SB/SH/SW into single-byte transfers on a narrow
// byte bus. It holds the pipeline with stallreq until every byte has been
// acknowledged. Non-memory ops pass straight through, with no added latency.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   rdy                 global enable; low freezes all state, mem_ack ignored
//   stall[5:0]          stall vector; only stall[3] (EX/MEM hold) is used
//   ex_wd/ex_wreg/ex_wdata         destination address/enable/ALU result
//   ex_mem_op           0 none,1 LB,2 LH,3 LW,4 LBU,5 LHU,6 SB,7 SH,8 SW
//                       (9-15 behave as none)
//   ex_mem_addr         byte address of the first byte (no alignment needed)
//   ex_store_data       store data, little-endian
//   mac_wd/mac_wreg/mac_wdata      write-back address/enable/data
//   stallreq            stall request to the stall controller
//   mem_req/mem_we/mem_addr/mem_dout   byte request, write flag, address, data
//   mem_din/mem_ack     read byte and its one-cycle completion pulse
//
// Optional feature (macro MEM_PERF_CNT_EN):
//   perf_stall_cycles   32-bit wrapping count of cycles with stallreq && rdy
// ----------------------------------------------------------------------------
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [5:0]  stall,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic [3:0]  ex_mem_op,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_store_data,
    output logic [4:0]  mac_wd,
    output logic        mac_wreg,
    output logic [31:0] mac_wdata,
    output logic        stallreq,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_dout,
    input  logic [7:0]  mem_din,
`ifdef MEM_PERF_CNT_EN
    output logic [31:0] perf_stall_cycles,
`endif
    input  logic        mem_ack
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] ld_buf_q, ld_buf_d;

    logic        is_mem;
    logic        is_store;
    logic [1:0]  last_cnt;
    logic [4:0]  byte_sh;
    logic [31:0] store_shift;

    // Only the EX/MEM hold bit of the stall vector matters here.
    logic unused_stall_bits;
    assign unused_stall_bits = ^{stall[5:4], stall[2:0]};

    // Sign- or zero-extend the assembled load buffer according to the op.
    function automatic logic [31:0] extend_load(input logic [3:0] op, input logic [31:0] b);
        case (op)
            4'd1:    extend_load = {{24{b[7]}}, b[7:0]};
            4'd2:    extend_load = {{16{b[15]}}, b[15:0]};
            4'd4:    extend_load = {24'd0, b[7:0]};
            4'd5:    extend_load = {16'd0, b[15:0]};
            default: extend_load = b;
        endcase
    endfunction

    always_comb begin
        is_mem   = (ex_mem_op >= 4'd1) && (ex_mem_op <= 4'd8);
        is_store = (ex_mem_op >= 4'd6) && (ex_mem_op <= 4'd8);
        case (ex_mem_op)
            4'd2, 4'd5, 4'd7: last_cnt = 2'd1;
            4'd3, 4'd8:       last_cnt = 2'd3;
            default:          last_cnt = 2'd0;
        endcase
        byte_sh     = {cnt_q, 3'b000};
        store_shift = ex_store_data >> byte_sh;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ld_buf_d  = ld_buf_q;
        mac_wd    = ex_wd;
        mac_wreg  = ex_wreg;
        mac_wdata = ex_wdata;
        stallreq  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_dout  = 8'd0;

        case (state_q)
            IDLE: begin
                if (is_mem) begin
                    stallreq = 1'b1;
                    mac_wreg = 1'b0;
                    if (rdy) begin
                        cnt_d   = 2'd0;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                mem_req  = 1'b1;
                mem_we   = is_store;
                mem_addr = ex_mem_addr + {30'd0, cnt_q};
                mem_dout = store_shift[7:0];
                stallreq = 1'b1;
                mac_wreg = 1'b0;
                if (rdy && mem_ack) begin
                    if (!is_store) begin
                        ld_buf_d = (ld_buf_q & ~(32'h0000_00FF << byte_sh))
                                 | ({24'd0, mem_din} << byte_sh);
                    end
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == last_cnt) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (is_store) begin
                    mac_wreg  = 1'b0;
                    mac_wdata = 32'd0;
                end else begin
                    mac_wdata = extend_load(ex_mem_op, ld_buf_q);
                end
                // Leaving only when the hold is released keeps a held
                // instruction from being issued to memory a second time.
                if (rdy && !stall[3]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are quiet for the whole time reset is asserted.
        if (rst) begin
            mac_wd    = 5'd0;
            mac_wreg  = 1'b0;
            mac_wdata = 32'd0;
            stallreq  = 1'b0;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = 32'd0;
            mem_dout  = 8'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            ld_buf_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ld_buf_q <= ld_buf_d;
        end
    end

`ifdef MEM_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (stallreq && rdy) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= 32'd0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall_cycles = perf_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [5:0]  stall;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic [3:0]  ex_mem_op;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_store_data;
    logic [4:0]  mac_wd;
    logic        mac_wreg;
    logic [31:0] mac_wdata;
    logic        stallreq;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        mem_ack;
`ifdef MEM_PERF_CNT_EN
    logic [31:0] perf_stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .stall         (stall),
        .ex_wd         (ex_wd),
        .ex_wreg       (ex_wreg),
        .ex_wdata      (ex_wdata),
        .ex_mem_op     (ex_mem_op),
        .ex_mem_addr   (ex_mem_addr),
        .ex_store_data (ex_store_data),
        .mac_wd        (mac_wd),
        .mac_wreg      (mac_wreg),
        .mac_wdata     (mac_wdata),
        .stallreq      (stallreq),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_dout      (mem_dout),
        .mem_din       (mem_din),
`ifdef MEM_PERF_CNT_EN
        .perf_stall_cycles (perf_stall_cycles),
`endif
        .mem_ack       (mem_ack)
    );

    // Reference: what a finished load should return, from the op's rules.
    function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] bytes);
        logic [31:0] b8, h16;
        b8  = bytes & 32'h0000_00FF;
        h16 = bytes & 32'h0000_FFFF;
        case (op)
            4'd1:    model_load = (b8 >= 32'd128)   ? b8 + 32'hFFFF_FF00 : b8;
            4'd2:    model_load = (h16 >= 32'd32768) ? h16 + 32'hFFFF_0000 : h16;
            4'd3:    model_load = bytes;
            4'd4:    model_load = b8;
            4'd5:    model_load = h16;
            default: model_load = 32'd0;
        endcase
    endfunction

    function automatic int model_nbytes(input logic [3:0] op);
        if (op == 4'd1 || op == 4'd4 || op == 4'd6) return 1;
        if (op == 4'd2 || op == 4'd5 || op == 4'd7) return 2;
        return 4;
    endfunction

    task automatic test_reset;
        rst = 1'b1; rdy = 1'b1; stall = 6'd0; mem_ack = 1'b0; mem_din = 8'd0;
        ex_mem_op = 4'd0; ex_wd = 5'd5; ex_wreg = 1'b1; ex_wdata = 32'h1234;
        ex_mem_addr = 32'd0; ex_store_data = 32'd0;
        @(negedge clk); #1;
        checks++;
        if ({mac_wd, mac_wreg, mac_wdata} !== 38'd0) begin
            errors++;
            $display("FAIL reset_mac got wd=%0h wreg=%0b wdata=%0h want all 0", mac_wd, mac_wreg, mac_wdata);
        end
        checks++;
        if ({stallreq, mem_req, mem_we} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl got stallreq=%0b mem_req=%0b mem_we=%0b want 000", stallreq, mem_req, mem_we);
        end
        // A memory op during reset must not raise any request.
        ex_mem_op = 4'd3;
        @(negedge clk); #1;
        checks++;
        if ({stallreq, mem_req} !== 2'b00) begin
            errors++;
            $display("FAIL reset_memop got stallreq=%0b mem_req=%0b want 00", stallreq, mem_req);
        end
        ex_mem_op = 4'd0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pass_through(input logic [3:0] op, input logic [4:0] wd, input logic wreg,
                                input logic [31:0] wdata, input string name);
        @(negedge clk);
        rdy = 1'b1; stall = 6'd0; mem_ack = 1'b0;
        ex_mem_op = op; ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata;
        #1;
        checks++;
        if ({mac_wd, mac_wreg, mac_wdata, stallreq, mem_req} !== {wd, wreg, wdata, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL %s got wd=%0h wreg=%0b wdata=%0h stallreq=%0b mem_req=%0b want wd=%0h wreg=%0b wdata=%0h stallreq=0 mem_req=0",
                     name, mac_wd, mac_wreg, mac_wdata, stallreq, mem_req, wd, wreg, wdata);
        end
    endtask

    // One complete memory instruction. ack delay per byte is drawn from
    // [dmin,dmax]; freeze_at inserts two rdy=0 cycles (with a stray ack) before
    // that byte; hold keeps stall[3] high for that many cycles in DONE.
    task automatic do_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] ldata, input int dmin, input int dmax,
                          input int freeze_at, input int hold, input string name);
        int n;
        int d;
        logic st;
        logic [31:0] exp_data;
        logic [31:0] exp_addr;
        logic [7:0]  exp_byte;
        logic [7:0]  in_byte;
        logic [4:0]  wd;
        n  = model_nbytes(op);
        st = (op >= 4'd6);
        exp_data = st ? 32'd0 : model_load(op, ldata);
        wd = 5'($urandom);

        @(negedge clk);
        rdy = 1'b1; stall = 6'd0; mem_ack = 1'b0; mem_din = 8'($urandom);
        ex_mem_op = op; ex_mem_addr = addr; ex_store_data = sdata;
        ex_wd = wd; ex_wreg = 1'b1; ex_wdata = $urandom;
        #1;
        checks++;
        if ({stallreq, mac_wreg, mem_req} !== 3'b100) begin
            errors++;
            $display("FAIL %s_issue got stallreq=%0b mac_wreg=%0b mem_req=%0b want 1 0 0", name, stallreq, mac_wreg, mem_req);
        end

        for (int i = 0; i < n; i++) begin
            exp_addr = addr + 32'(i);
            exp_byte = 8'((sdata >> (8 * i)) & 32'hFF);
            in_byte  = 8'((ldata >> (8 * i)) & 32'hFF);
            if (i == freeze_at) begin
                for (int f = 0; f < 2; f++) begin
                    @(negedge clk);
                    rdy = 1'b0; mem_ack = 1'b1; mem_din = ~in_byte;
                    #1;
                    checks++;
                    if ({mem_req, stallreq, mem_addr} !== {1'b1, 1'b1, exp_addr}) begin
                        errors++;
                        $display("FAIL %s_freeze byte %0d got req=%0b stallreq=%0b addr=%0h want 1 1 %0h",
                                 name, i, mem_req, stallreq, mem_addr, exp_addr);
                    end
                end
            end
            d = $urandom_range(dmax, dmin);
            for (int w = 0; w <= d; w++) begin
                @(negedge clk);
                rdy = 1'b1;
                mem_ack = (w == d);
                mem_din = (w == d) ? in_byte : 8'($urandom);
                #1;
                checks++;
                if ({mem_req, mem_we, stallreq, mac_wreg, mem_addr} !== {1'b1, st, 1'b1, 1'b0, exp_addr}) begin
                    errors++;
                    $display("FAIL %s_busy byte %0d got req=%0b we=%0b stallreq=%0b wreg=%0b addr=%0h want 1 %0b 1 0 %0h",
                             name, i, mem_req, mem_we, stallreq, mac_wreg, mem_addr, st, exp_addr);
                end
                if (st) begin
                    checks++;
                    if (mem_dout !== exp_byte) begin
                        errors++;
                        $display("FAIL %s_dout byte %0d got %0h want %0h", name, i, mem_dout, exp_byte);
                    end
                end
            end
        end

        // DONE: a stray ack here must be ignored.
        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            mem_ack = 1'b1; mem_din = 8'($urandom);
            stall = (h < hold) ? 6'b001000 : 6'b000000;
            #1;
            checks++;
            if ({stallreq, mem_req, mac_wd, mac_wreg, mac_wdata} !== {1'b0, 1'b0, wd, ~st, exp_data}) begin
                errors++;
                $display("FAIL %s_done cyc %0d got stallreq=%0b req=%0b wd=%0h wreg=%0b wdata=%0h want 0 0 %0h %0b %0h",
                         name, h, stallreq, mem_req, mac_wd, mac_wreg, mac_wdata, wd, ~st, exp_data);
            end
        end

        pass_through(4'd0, 5'($urandom), 1'b1, $urandom, {name, "_after"});
    endtask

    task automatic test_directed;
        pass_through(4'd0, 5'd5, 1'b1, 32'h1234, "passthru_basic");
        do_mem(4'd1, 32'h100, 32'd0, 32'h80, 0, 0, -1, 0, "lb_neg");
        do_mem(4'd4, 32'h100, 32'd0, 32'h80, 0, 0, -1, 0, "lbu");
        do_mem(4'd8, 32'hFFFF_FFFE, 32'hAABB_CCDD, 32'd0, 0, 0, -1, 0, "sw_wrap");
        do_mem(4'd3, 32'h2000, 32'd0, 32'h4433_2211, 3, 3, -1, 0, "lw_slow");
        do_mem(4'd2, 32'h301, 32'd0, 32'h0000_8001, 0, 0, -1, 2, "lh_hold");
        do_mem(4'd5, 32'h303, 32'd0, 32'h0000_8001, 0, 1, 1, 1, "lhu_freeze");
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        rdy = 1'b1; stall = 6'd0; mem_ack = 1'b0;
        ex_mem_op = 4'd3; ex_mem_addr = 32'h400; ex_wd = 5'd7; ex_wreg = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            mem_ack = 1'b1; mem_din = 8'(i + 1);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({mem_req, stallreq, mac_wreg} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid got req=%0b stallreq=%0b wreg=%0b want 000", mem_req, stallreq, mac_wreg);
        end
        @(negedge clk);
        ex_mem_op = 4'd0;
        rst = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_release got req=%0b want 0", mem_req);
        end
        pass_through(4'd0, 5'd9, 1'b1, 32'hCAFE_F00D, "reset_mid_pass");
        // Restart from byte 0 proves the byte counter was cleared.
        do_mem(4'd1, 32'h500, 32'd0, 32'h7F, 0, 0, -1, 0, "reset_mid_lb");
    endtask

    task automatic test_random;
        logic [3:0]  op;
        logic [31:0] addr;
        for (int k = 0; k < 16; k++) begin
            op   = 4'($urandom_range(8, 1));
            addr = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(3, 0))) : $urandom;
            do_mem(op, addr, $urandom, $urandom, 0, 2, $urandom_range(4, 0) - 1, $urandom_range(2, 0), "rand_mem");
            op = ($urandom_range(1, 0) == 0) ? 4'd0 : 4'($urandom_range(15, 9));
            pass_through(op, 5'($urandom), 1'($urandom), $urandom, "rand_pass");
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  async reset, active-high.
REQ-004 rdy  in  1  global enable; low freezes all state and ignores mem_ack.
REQ-005 stall  in  6  pipeline stall vector; only stall[3] (EX/MEM register hold) is used.
REQ-006 ex_wd  in  5  destination register address.
REQ-007 ex_wreg  in  1  destination write enable.
REQ-008 ex_wdata  in  32  ALU result; passed through for non-memory ops.
REQ-009 ex_mem_op  in  4  memory op: 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; 9-15 treated as none.
REQ-010 ex_mem_addr  in  32  byte address of the first byte.
REQ-011 ex_store_data  in  32  store data, little-endian.
REQ-012 mac_wd  out  5  write-back register address.
REQ-013 mac_wreg  out  1  write-back enable.
REQ-014 mac_wdata  out  32  write-back data.
REQ-015 stallreq  out  1  stall request to the stall controller.
REQ-016 mem_req  out  1  byte-access request.
REQ-017 mem_we  out  1  1 = write, 0 = read.
REQ-018 mem_addr  out  32  byte address.
REQ-019 mem_dout  out  8  write byte.
REQ-020 mem_din  in  8  read byte; valid when mem_ack is high.
REQ-021 mem_ack  in  1  one-cycle completion pulse for the current byte.

Function
REQ-022 States SHALL be IDLE, BUSY and DONE; nbytes SHALL be 1 for B/BU, 2 for H/HU and 4 for W.
REQ-023 In IDLE with op none, outputs SHALL be combinational pass-through: mac_wd=ex_wd, mac_wreg=ex_wreg, mac_wdata=ex_wdata, stallreq=0.
REQ-024 In IDLE with a memory op, stallreq SHALL be 1, mac_wreg SHALL be 0, cnt SHALL clear to 0, and the next state SHALL be BUSY.
REQ-025 In BUSY the block SHALL drive mem_req=1, mem_addr=ex_mem_addr+cnt (mod 2^32), mem_we=1 for SB/SH/SW, mem_dout=ex_store_data[8*cnt+7:8*cnt], stallreq=1 and mac_wreg=0.
REQ-026 In BUSY on mem_ack, a load SHALL store mem_din into buf[8*cnt+7:8*cnt] and cnt SHALL increment; when cnt==nbytes-1 the next state SHALL be DONE.
REQ-027 In DONE: stallreq=0 and mem_req=0; loads output mac_wd=ex_wd, mac_wreg=ex_wreg, and mac_wdata = buf sign-extended (LB/LH), zero-extended (LBU/LHU) or whole (LW); stores output mac_wreg=0 and mac_wdata=0.
REQ-028 DONE SHALL go to IDLE when stall[3]=0 and SHALL stay in DONE while stall[3]=1, so a held instruction is never re-issued.
REQ-029 mem_ack outside BUSY SHALL be ignored; no alignment is required; ex_* inputs are held stable by upstream while stallreq=1.
REQ-030 When rdy=0, state, cnt and buf SHALL hold, outputs SHALL follow the held state, and mem_ack SHALL be ignored.
REQ-031 With one-cycle ack, a W op SHALL hold stallreq high for 5 cycles (IDLE plus 4 in BUSY) and a B op for 2 cycles.

Reset
REQ-032 rst SHALL asynchronously force IDLE, cnt=0 and buf=0, including mid-transfer; mem_req SHALL drop immediately and no further bytes SHALL be issued.
REQ-033 During reset, mem_req=0, mem_we=0, stallreq=0, mac_wreg=0, mac_wd=0 and mac_wdata=0.

Configuration
REQ-034 With MEM_PERF_CNT_EN defined, a 32-bit output perf_stall_cycles SHALL count cycles where stallreq=1 and rdy=1, wrapping at 2^32, and SHALL reset to 0.
REQ-035 Without MEM_PERF_CNT_EN, the perf_stall_cycles port and counter SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-036 Non-memory op, ex_wd=5, ex_wreg=1, ex_wdata=0x1234 -> same cycle mac_*=(5,1,0x1234), stallreq=0, mem_req=0.
REQ-037 LB at 0x100, ack every cycle, mem_din=0x80 -> one read at 0x100, then DONE with mac_wdata=0xFFFFFF80; LBU gives 0x00000080.
REQ-038 SW 0xAABBCCDD at 0xFFFFFFFE, ack every cycle -> writes DD@FFFFFFFE, CC@FFFFFFFF, BB@0, AA@1; stallreq high 5 cycles; mac_wreg=0.
REQ-039 LW with acks delayed 3 cycles each, bytes 11,22,33,44 -> mac_wdata=0x44332211; mem_addr stable while waiting; stallreq falls only in DONE.
REQ-040 LH in DONE with stall[3]=1 for 2 cycles -> stays DONE with mac_wdata stable, no new mem_req, then IDLE.
REQ-041 rst pulse after second byte of LW -> immediate IDLE, mem_req=0; a following non-memory op passes through normally.
